// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: operands are latched once, then added one 4-bit
// carry-lookahead slice per cycle, LSB nibble first, with a held result handshake.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTEP = WIDTH / 4;
  localparam int SW    = $clog2(NSTEP) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic             init_q;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [SW-1:0]    step_q, step_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic             accept, last_step;
  logic [3:0]       a_nib, b_nib, p, g, s_nib;
  logic [4:0]       c;

  assign accept    = in_valid && in_ready;
  assign last_step = (step_q == SW'(NSTEP - 1));

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NSTEP; n++) begin
      if (step_q == SW'(n)) begin
        a_nib = a_q[n*4 +: 4];
        b_nib = b_q[n*4 +: 4];
      end
    end
  end

  // Two-level lookahead: every carry is formed directly from P/G and the slice carry-in.
  always_comb begin
    p    = a_nib ^ b_nib;
    g    = a_nib & b_nib;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s_nib = p ^ c[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // init_q keeps in_ready low until the first edge after reset is released.
  always_comb begin
    in_ready  = (state_q == IDLE) && init_q;
    out_valid = (state_q == DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    step_d  = step_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          step_d  = '0;
        end
      end
      BUSY: begin
        for (int n = 0; n < NSTEP; n++) begin
          if (step_q == SW'(n)) sum_d[n*4 +: 4] = s_nib;
        end
        carry_d = c[4];
        step_d  = step_q + SW'(1);
        if (last_step) begin
          cout_d = c[4];
          ovf_d  = c[3] ^ c[4];
          zero_d = (sum_d == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      step_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      init_q  <= 1'b1;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      step_q  <= step_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 The block SHALL derive NSTEP = WIDTH/4, the number of nibble steps per operation.
REQ-003 The block SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL provide port in_valid, input, 1 bit: operand request valid.
REQ-006 The block SHALL provide port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL provide port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL provide port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL provide port cin, input, 1 bit: carry-in to bit 0.
REQ-010 The block SHALL provide port out_valid, output, 1 bit: result valid.
REQ-011 The block SHALL provide port out_ready, input, 1 bit: consumer accepts result.
REQ-012 The block SHALL provide port sum, output, WIDTH bits: a + b + cin, modulo 2^WIDTH.
REQ-013 The block SHALL provide port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-014 The block SHALL provide port ovf, output, 1 bit: two's-complement overflow, i.e. carry into MSB XOR carry out of MSB.
REQ-015 The block SHALL provide port zero, output, 1 bit: asserted when sum == 0.

Function
REQ-016 The block SHALL implement three states: IDLE, BUSY and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 In IDLE, when in_valid=1, the block SHALL latch a, b and cin into internal registers, clear the step counter to 0, and enter BUSY.
REQ-019 In BUSY, each cycle SHALL add one nibble, least significant first, using a 4-bit carry-lookahead slice (P = a^b, G = a&b, two-level lookahead carry) and the registered carry.
REQ-020 At the end of each BUSY cycle, the block SHALL write the 4 sum bits into nibble [step] of the sum register, register the carry-out as the next carry-in, and increment step.
REQ-021 On the cycle where step == NSTEP-1, the block SHALL additionally capture cout, capture ovf (slice C[3] XOR C[4]), compute zero from the final sum, and enter DONE.
REQ-022 Latency: if operands are accepted at edge t, out_valid SHALL rise after edge t+NSTEP (4 cycles for WIDTH=16); throughput SHALL be one result per NSTEP+2 cycles with out_ready tied high.
REQ-023 In DONE, sum, cout, ovf and zero SHALL be held stable while out_ready=0, for any number of cycles.
REQ-024 In DONE with out_ready=1, the block SHALL return to IDLE at the next edge; a new request SHALL NOT be accepted in that same cycle.
REQ-025 in_valid, a, b and cin SHALL be ignored in BUSY and DONE; operand changes after acceptance SHALL not affect the result.
REQ-026 The step counter SHALL be $clog2(NSTEP)+1 bits wide and SHALL never exceed NSTEP-1 while in BUSY.
REQ-027 Results SHALL be arithmetically exact for all corner cases, including cin=1 with all-ones operands, where carry ripples through every nibble step.

Reset
REQ-028 While rst=1, the block SHALL force the state to IDLE; operand registers, sum, step and the carry register to 0; and cout, ovf, zero and out_valid to 0.
REQ-029 in_ready SHALL be 0 while rst=1 and SHALL become 1 on the first clock edge after rst deasserts.
REQ-030 Reset asserted in BUSY or DONE SHALL abort the operation immediately, with no result delivered; the first post-reset request SHALL compute correctly.

Verification
REQ-031 Ripple case: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0, zero=1; out_valid exactly 4 cycles after accept.
REQ-032 Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1, zero=0.
REQ-033 Full carry chain: a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0, zero=0.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling a, b and in_valid -> outputs stable, in_ready=0, no new accept; then out_ready=1 -> IDLE next cycle.
REQ-035 Reset mid-op: assert rst at step 2 of a=0x1234, b=0x4321 -> all outputs 0 immediately; then a=0x0F0F, b=0x00F1, cin=0 -> sum=0x1000.
REQ-036 Random: 10k random a, b, cin with random in_valid/out_ready gaps -> every result matches the reference model; no result is lost or duplicated.
